// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback stage: buffers one result per FU, grants one per cycle round-robin,
// broadcasts it and drives the WAW-safe register-file / status-clear writes. Optional: CDB_STATS_EN.
module cdb_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 4,
    parameter int FU_INDEX  = 3,
    parameter int NUM_FU    = 4,
    parameter int READY     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_valid,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic [NUM_FU*REG_INDEX-1:0]   fu_dest,
    input  logic [NUM_FU*WORD_SIZE-1:0]   fu_data,
    output logic                          cdb_valid,
    output logic [FU_INDEX-1:0]           cdb_tag,
    output logic [REG_INDEX-1:0]          cdb_dest,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [REG_INDEX-1:0]          query_num,
    input  logic [FU_INDEX-1:0]           query_status,
    input  logic [REG_INDEX-1:0]          issue_rs_src,
    input  logic                          issue_rs_enable,
    output logic [REG_INDEX-1:0]          write_reg_src,
    output logic [WORD_SIZE-1:0]          write_reg_data,
    output logic                          write_reg_enable,
    output logic [REG_INDEX-1:0]          write_rs_src2,
    output logic [FU_INDEX-1:0]           write_rs_status2,
    output logic                          write_rs_enable2
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]                   stat_bcast,
    output logic [15:0]                   stat_stall
`endif
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    r_full;
    logic [REG_INDEX-1:0] r_dest [NUM_FU];
    logic [WORD_SIZE-1:0] r_data [NUM_FU];
    logic [PTR_W-1:0]     r_rr_ptr;

    logic                 r_cdb_valid;
    logic [FU_INDEX-1:0]  r_cdb_tag;
    logic [REG_INDEX-1:0] r_cdb_dest;
    logic [WORD_SIZE-1:0] r_cdb_data;

    logic                 w_any;
    logic [PTR_W-1:0]     w_gidx;
    logic [NUM_FU-1:0]    w_grant;
    logic [PTR_W-1:0]     w_rr_next;
    logic [NUM_FU-1:0]    w_fu_ready;
    logic                 w_match;
    logic                 w_issue_hit;

    // Round-robin search: first full buffer at or after r_rr_ptr, wrapping to 0.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        w_any   = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU))
                sum = sum - (PTR_W+1)'(NUM_FU);
            idx = sum[PTR_W-1:0];
            if (!w_any && r_full[idx]) begin
                w_any  = 1'b1;
                w_gidx = idx;
            end
        end
        if (w_any)
            w_grant[w_gidx] = 1'b1;
    end

    assign w_rr_next  = (w_gidx == PTR_W'(NUM_FU - 1)) ? '0 : w_gidx + PTR_W'(1);
    assign w_fu_ready = ~r_full | w_grant;
    assign fu_ready   = w_fu_ready;

    // A buffer being granted can be refilled on the same edge, so load wins over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && w_fu_ready[i])
                    r_full[i] <= 1'b1;
                else if (w_grant[i])
                    r_full[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && w_fu_ready[i]) begin
                r_dest[i] <= fu_dest[i*REG_INDEX +: REG_INDEX];
                r_data[i] <= fu_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_dest  <= '0;
            r_cdb_data  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= FU_INDEX'(w_gidx) + FU_INDEX'(1);
            r_cdb_dest  <= r_dest[w_gidx];
            r_cdb_data  <= r_data[w_gidx];
            r_rr_ptr    <= w_rr_next;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_dest  = r_cdb_dest;
    assign cdb_data  = r_cdb_data;
    assign query_num = r_cdb_dest;

    // Only write back if the destination is still waiting on this FU; a same-cycle rename keeps its status.
    assign w_match     = r_cdb_valid && (query_status == r_cdb_tag);
    assign w_issue_hit = issue_rs_enable && (issue_rs_src == r_cdb_dest);

    assign write_reg_enable = w_match;
    assign write_reg_src    = r_cdb_dest;
    assign write_reg_data   = r_cdb_data;
    assign write_rs_enable2 = w_match && !w_issue_hit;
    assign write_rs_src2    = r_cdb_dest;
    assign write_rs_status2 = FU_INDEX'(READY);

`ifdef CDB_STATS_EN
    logic [15:0] r_stat_bcast;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_bcast <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_cdb_valid)
                r_stat_bcast <= r_stat_bcast + 16'd1;
            if (|(fu_valid & ~w_fu_ready))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_bcast = r_stat_bcast;
    assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a transaction-level
// model of pending results, round-robin order and writeback rules. Handles CDB_STATS_EN.
module tb_cdb_arbiter;
    localparam int WS = 32;
    localparam int RI = 4;
    localparam int FI = 3;
    localparam int NF = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NF-1:0]     fu_valid = '0;
    logic [NF-1:0]     fu_ready;
    logic [NF*RI-1:0]  fu_dest = '0;
    logic [NF*WS-1:0]  fu_data = '0;
    logic              cdb_valid;
    logic [FI-1:0]     cdb_tag;
    logic [RI-1:0]     cdb_dest;
    logic [WS-1:0]     cdb_data;
    logic [RI-1:0]     query_num;
    logic [FI-1:0]     query_status = '0;
    logic [RI-1:0]     issue_rs_src = '0;
    logic              issue_rs_enable = 1'b0;
    logic [RI-1:0]     write_reg_src;
    logic [WS-1:0]     write_reg_data;
    logic              write_reg_enable;
    logic [RI-1:0]     write_rs_src2;
    logic [FI-1:0]     write_rs_status2;
    logic              write_rs_enable2;
`ifdef CDB_STATS_EN
    logic [15:0]       stat_bcast;
    logic [15:0]       stat_stall;
`endif

    cdb_arbiter #(.WORD_SIZE(WS), .REG_INDEX(RI), .FU_INDEX(FI), .NUM_FU(NF), .READY(0)) dut (
        .clk(clk), .reset(reset),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_dest(fu_dest), .fu_data(fu_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_dest(cdb_dest), .cdb_data(cdb_data),
        .query_num(query_num), .query_status(query_status),
        .issue_rs_src(issue_rs_src), .issue_rs_enable(issue_rs_enable),
        .write_reg_src(write_reg_src), .write_reg_data(write_reg_data),
        .write_reg_enable(write_reg_enable),
        .write_rs_src2(write_rs_src2), .write_rs_status2(write_rs_status2),
        .write_rs_enable2(write_rs_enable2)
`ifdef CDB_STATS_EN
        , .stat_bcast(stat_bcast), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference: one pending result per FU, the FU served last, and the current broadcast.
    bit            pend      [NF];
    logic [RI-1:0] pend_dest [NF];
    logic [WS-1:0] pend_data [NF];
    int            last_served;
    bit            exp_v;
    int            exp_tag;
    logic [RI-1:0] exp_dest;
    logic [WS-1:0] exp_data;
    int unsigned   exp_bcast, exp_stall;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int next_served();
        for (int k = 1; k <= NF; k++) begin
            int fu;
            fu = (last_served + k) % NF;
            if (pend[fu]) return fu;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) pend[i] = 1'b0;
        last_served = NF - 1;
        exp_v = 1'b0; exp_tag = 0; exp_dest = '0; exp_data = '0;
        exp_bcast = 0; exp_stall = 0;
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        int            g;
        logic [NF-1:0] rdy;
        bit            match, renamed;
        g = next_served();
        for (int i = 0; i < NF; i++) rdy[i] = !pend[i] || (g == i);
        @(negedge clk);
        check("fu_ready", fu_ready, rdy);
        check("cdb_valid", cdb_valid, exp_v);
        check("cdb_tag", cdb_tag, exp_tag);
        check("cdb_dest", cdb_dest, exp_dest);
        check("cdb_data", cdb_data, exp_data);
        check("query_num", query_num, exp_dest);
        match   = exp_v && (int'(query_status) == exp_tag);
        renamed = issue_rs_enable && (issue_rs_src == exp_dest);
        check("wr_reg_en", write_reg_enable, match);
        check("wr_reg_src", write_reg_src, exp_dest);
        check("wr_reg_data", write_reg_data, exp_data);
        check("wr_rs_en", write_rs_enable2, match && !renamed);
        check("wr_rs_src", write_rs_src2, exp_dest);
        check("wr_rs_status", write_rs_status2, 0);
`ifdef CDB_STATS_EN
        check("stat_bcast", stat_bcast, exp_bcast % 65536);
        check("stat_stall", stat_stall, exp_stall % 65536);
`endif
        if (exp_v) exp_bcast++;
        if (|(fu_valid & ~rdy)) exp_stall++;
        if (g >= 0) begin
            exp_v = 1'b1; exp_tag = g + 1;
            exp_dest = pend_dest[g]; exp_data = pend_data[g];
            last_served = g; pend[g] = 1'b0;
        end else begin
            exp_v = 1'b0;
        end
        for (int i = 0; i < NF; i++) begin
            if (fu_valid[i] && rdy[i]) begin
                pend[i] = 1'b1;
                pend_dest[i] = fu_dest[i*RI +: RI];
                pend_data[i] = fu_data[i*WS +: WS];
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic do_reset();
        fu_valid = '0;
        issue_rs_enable = 1'b0;
        #2 reset = 1'b1;
        #1 check("rst_cdb_valid_async", cdb_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_dest", cdb_dest, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_fu_ready", fu_ready, {NF{1'b1}});
        check("rst_wr_reg_en", write_reg_enable, 0);
        check("rst_wr_rs_en", write_rs_enable2, 0);
`ifdef CDB_STATS_EN
        check("rst_stat_bcast", stat_bcast, 0);
        check("rst_stat_stall", stat_stall, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int fu, input logic [RI-1:0] d, input logic [WS-1:0] v);
        fu_valid[fu] = 1'b1;
        fu_dest[fu*RI +: RI] = d;
        fu_data[fu*WS +: WS] = v;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single result, matching status: written and cleared.
        offer(0, 4'd5, 32'hA5);
        query_status = 3'd1;
        cycle();
        fu_valid = '0;
        cycle();
        check("t1_valid", cdb_valid, 1);
        check("t1_tag", cdb_tag, 1);
        check("t1_wr_en", write_reg_enable, 1);
        check("t1_wr_src", write_reg_src, 5);
        check("t1_wr_data", write_reg_data, 32'hA5);
        check("t1_rs_en", write_rs_enable2, 1);

        // All four offer together from pointer 0.
        do_reset();
        for (int i = 0; i < NF; i++) offer(i, RI'(i + 8), WS'(32'h100 + i));
        cycle();
        fu_valid = '0;
        for (int k = 1; k <= NF; k++) begin
            cycle();
            check("t2_valid", cdb_valid, 1);
            check("t2_tag", cdb_tag, k);
        end
        cycle();
        check("t2_idle", cdb_valid, 0);

        // Renamed destination: broadcast without writes.
        offer(1, 4'd3, 32'h33);
        cycle();
        fu_valid = '0;
        query_status = 3'd4;
        cycle();
        check("t3_valid", cdb_valid, 1);
        check("t3_wr_en", write_reg_enable, 0);
        check("t3_rs_en", write_rs_enable2, 0);

        // Same-cycle issue rename of the destination blocks only the status clear.
        offer(3, 4'd7, 32'h77);
        cycle();
        fu_valid = '0;
        query_status = 3'd4;
        issue_rs_enable = 1'b1;
        issue_rs_src = 4'd7;
        cycle();
        check("t4_wr_en", write_reg_enable, 1);
        check("t4_rs_en", write_rs_enable2, 0);
        issue_rs_enable = 1'b0;

        // FU2 back-pressured until its grant, then refilled with no bubble.
        do_reset();
        offer(0, 4'd1, 32'h11);
        offer(1, 4'd2, 32'h22);
        offer(2, 4'd3, 32'h33);
        cycle();
        fu_valid = 4'b0100;
        fu_data[2*WS +: WS] = 32'h44;
        #1 check("t5_busy0", fu_ready[2], 0);
        cycle();
        #1 check("t5_busy1", fu_ready[2], 0);
        cycle();
        #1 check("t5_ready", fu_ready[2], 1);
        cycle();
        check("t5_old_data", cdb_data, 32'h33);
        fu_valid = '0;
        cycle();
        check("t5_new_valid", cdb_valid, 1);
        check("t5_new_tag", cdb_tag, 3);
        check("t5_new_data", cdb_data, 32'h44);

        // Reset during a live broadcast with buffers full.
        offer(0, 4'd1, 32'h1);
        offer(1, 4'd2, 32'h2);
        offer(3, 4'd4, 32'h4);
        cycle();
        fu_valid = '0;
        cycle();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t6_no_stale", cdb_valid, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            fu_valid = NF'($urandom);
            fu_dest  = NF*RI'($urandom);
            for (int i = 0; i < NF; i++) fu_data[i*WS +: WS] = $urandom;
            query_status    = ($urandom % 2 == 0) ? FI'(exp_tag) : FI'($urandom);
            issue_rs_enable = 1'($urandom);
            issue_rs_src    = ($urandom % 2 == 0) ? exp_dest : RI'($urandom);
            if ($urandom % 97 == 0)
                do_reset();
            else
                cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
